// File: rtl/pool_feed_tx.sv
// Captures one raster-order three-channel feature map, then replays it in 2x2-window order.
// Optional overrun/hold checking is compiled in with POOL_FEED_TX_CHECK_EN.
module pool_feed_tx #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_feature [3:1],
  output logic                 in_ready,
  input  logic                 tx_hold,
  output logic                 out_start,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_feature [3:1],
  output logic                 out_win_last,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 err
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam int WXW  = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam int WYW  = (IMG_H > 2) ? $clog2(IMG_H / 2) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_next;
  logic [AW-1:0]        load_cnt;
  logic [AW-1:0]        wr_addr;
  logic [AW-1:0]        rd_addr;
  logic [WXW-1:0]       wx;
  logic [WYW-1:0]       wy;
  logic [1:0]           k;
  logic                 accept;
  logic                 wr_en;
  logic                 issue;
  logic                 wx_last;
  logic                 wy_last;
  logic                 first_win;
  logic                 last_read;
  logic                 last_load;

  logic signed [DW-1:0] mem1 [NPIX];
  logic signed [DW-1:0] mem2 [NPIX];
  logic signed [DW-1:0] mem3 [NPIX];

  always_comb begin
    accept     = in_valid && in_ready;
    wr_en      = accept && ((state == S_IDLE) || (state == S_LOAD));
    wr_addr    = (state == S_IDLE) ? '0 : load_cnt;
    last_load  = wr_en && (state == S_LOAD) && (load_cnt == AW'(NPIX - 1));
    issue      = (state == S_SEND) && !tx_hold;
    wx_last    = (wx == WXW'(IMG_W / 2 - 1));
    wy_last    = (wy == WYW'(IMG_H / 2 - 1));
    first_win  = (wx == '0) && (wy == '0) && (k == 2'd0);
    last_read  = issue && wx_last && wy_last && (k == 2'd3);
    rd_addr    = AW'((2 * int'(wy) + int'(k[1])) * IMG_W + 2 * int'(wx) + int'(k[0]));
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_LOAD;
      S_LOAD:  if (last_load) state_next = S_SEND;
      S_SEND:  if (last_read) state_next = S_DRAIN;
      S_DRAIN: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem1[wr_addr] <= in_feature[1];
      mem2[wr_addr] <= in_feature[2];
      mem3[wr_addr] <= in_feature[3];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      load_cnt       <= '0;
      wx             <= '0;
      wy             <= '0;
      k              <= '0;
      in_ready       <= 1'b0;
      out_start      <= 1'b0;
      out_valid      <= 1'b0;
      out_win_last   <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
      out_feature[1] <= '0;
      out_feature[2] <= '0;
      out_feature[3] <= '0;
    end else begin
      state <= state_next;

      if (last_load) begin
        load_cnt <= '0;
      end else if (wr_en) begin
        load_cnt <= (state == S_IDLE) ? AW'(1) : load_cnt + AW'(1);
      end

      if (issue) begin
        if (k == 2'd3) begin
          k <= '0;
          if (wx_last) begin
            wx <= '0;
            wy <= wy_last ? '0 : wy + WYW'(1);
          end else begin
            wx <= wx + WXW'(1);
          end
        end else begin
          k <= k + 2'd1;
        end
      end

      // frame_done lands in the first IDLE cycle; loading reopens one cycle later.
      in_ready     <= (state_next == S_LOAD) || ((state_next == S_IDLE) && (state != S_DONE));
      busy         <= (state_next != S_IDLE);
      frame_done   <= (state == S_DONE);
      out_valid    <= issue;
      out_start    <= issue && first_win;
      out_win_last <= issue && (k == 2'd3);
      out_feature[1] <= issue ? mem1[rd_addr] : '0;
      out_feature[2] <= issue ? mem2[rd_addr] : '0;
      out_feature[3] <= issue ? mem3[rd_addr] : '0;
    end
  end

`ifdef POOL_FEED_TX_CHECK_EN
  logic [2:0] hold_cnt;
  logic       err_set;

  // A hold longer than four cycles risks splitting a window at the pool stage.
  always_comb begin
    err_set = (in_valid && !in_ready &&
               ((state == S_SEND) || (state == S_DRAIN) || (state == S_DONE))) ||
              ((state == S_SEND) && tx_hold && (hold_cnt >= 3'd4));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if ((state == S_SEND) && tx_hold) begin
        hold_cnt <= (hold_cnt == 3'd7) ? hold_cnt : hold_cnt + 3'd1;
      end else begin
        hold_cnt <= '0;
      end
      if (err_set) begin
        err <= 1'b1;
      end
`ifndef SYNTHESIS
      if (err_set && !err) begin
        $display("Running Error");
      end
`endif
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
